// File: rtl/pattern_det_ctrl_if.sv
// Configuration channel of the pattern detector: one valid/ready transfer
// carries pattern, length, threshold and overlap mode.
interface pattern_det_ctrl_if #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LEN_W  = $clog2(MAXLEN + 1)
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]  cfg_len;
    logic [CNT_W-1:0]  cfg_thresh;
    logic              cfg_overlap;

    modport master (
        output cfg_valid,
        output cfg_pattern,
        output cfg_len,
        output cfg_thresh,
        output cfg_overlap,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pattern,
        input  cfg_len,
        input  cfg_thresh,
        input  cfg_overlap,
        output cfg_ready
    );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Programmable serial pattern detector: configurable pattern/length/overlap,
// saturating match counter and sticky threshold interrupt.
module pattern_det_ctrl #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LEN_W  = $clog2(MAXLEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    pattern_det_ctrl_if.slave  cfg,
    input  logic               start,
    input  logic               stop,
    input  logic               in_valid,
    input  logic               in,
    output logic               det,
    output logic [CNT_W-1:0]   count,
    output logic               irq,
    input  logic               irq_clr,
    output logic [1:0]         state
);

    localparam int unsigned HIST_W = MAXLEN - 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [MAXLEN-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    thresh_q, thresh_d;
    logic                ovl_q, ovl_d;
    logic                loaded_q, loaded_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [LEN_W-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                irq_q, irq_d;
    logic                rdy_q;

    logic [MAXLEN-1:0]   win;
    logic [MAXLEN-1:0]   mask;
    logic                match;
    logic                det_c;
    logic                entry;
    logic [CNT_W-1:0]    count_inc;
    logic                hit_thresh;
    logic [LEN_W-1:0]    len_clamp;

    // Compare window: only the low len bits participate, and only once enough bits arrived
    always_comb begin
        mask = '0;
        for (int i = 0; i < int'(MAXLEN); i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign win   = {hist_q, in};
    assign match = (((win ^ pat_q) & mask) == '0) &&
                   (((LEN_W+1)'(fill_q) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q));

    assign count_inc  = (&count_q) ? count_q : count_q + CNT_W'(1);
    assign hit_thresh = (thresh_q != '0) &&
                        (((CNT_W+1)'(count_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(thresh_q));

    assign len_clamp = ((cfg.cfg_len == '0) || (cfg.cfg_len > LEN_W'(MAXLEN))) ?
                       LEN_W'(MAXLEN) : cfg.cfg_len;

    // Next-state, datapath and Mealy strobe
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        thresh_d = thresh_q;
        ovl_d    = ovl_q;
        loaded_d = loaded_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        count_d  = count_q;
        irq_d    = irq_q & ~irq_clr;
        det_c    = 1'b0;
        entry    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg.cfg_valid && rdy_q) begin
                    pat_d    = cfg.cfg_pattern;
                    len_d    = len_clamp;
                    thresh_d = cfg.cfg_thresh;
                    ovl_d    = cfg.cfg_overlap;
                    loaded_d = 1'b1;
                end
                if (start && loaded_q && !stop) begin
                    state_d = RUN;
                    entry   = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    hist_d = HIST_W'({hist_q, in});
                    fill_d = (fill_q == LEN_W'(MAXLEN)) ? fill_q : fill_q + LEN_W'(1);
                    if (match) begin
                        det_c   = 1'b1;
                        count_d = count_inc;
                        // Non-overlapping mode: matched bits must not seed the next match
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
                        if (hit_thresh) begin
                            irq_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    entry   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (entry) begin
            count_d = '0;
            hist_d  = '0;
            fill_d  = '0;
            irq_d   = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            thresh_q <= '0;
            ovl_q    <= 1'b0;
            loaded_q <= 1'b0;
            hist_q   <= '0;
            fill_q   <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            thresh_q <= thresh_d;
            ovl_q    <= ovl_d;
            loaded_q <= loaded_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
            rdy_q    <= (state_d == IDLE);
        end
    end

    assign cfg.cfg_ready = rdy_q;
    assign det           = det_c;
    assign count         = count_q;
    assign irq           = irq_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl; expected det values travel through a
// scoreboard queue from the driving step to the sampling point.
module tb_pattern_det_ctrl;

    localparam int unsigned MAXLEN = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned LEN_W  = $clog2(MAXLEN + 1);

    logic             clock;
    logic             reset;
    logic             start;
    logic             stop;
    logic             in_valid;
    logic             in_bit;
    logic             irq_clr;
    logic             det;
    logic [CNT_W-1:0] count;
    logic             irq;
    logic [1:0]       state;

    int n_assert = 0;
    int n_fail   = 0;
    logic exp_q[$];

    pattern_det_ctrl_if #(.MAXLEN(MAXLEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) cfg_bus ();

    pattern_det_ctrl #(.MAXLEN(MAXLEN), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg      (cfg_bus),
        .start    (start),
        .stop     (stop),
        .in_valid (in_valid),
        .in       (in_bit),
        .det      (det),
        .count    (count),
        .irq      (irq),
        .irq_clr  (irq_clr),
        .state    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus, driven on the falling edge; det is checked against the scoreboard
    task automatic step(input logic v, input logic b, input logic st, input logic sp,
                        input logic clr, input logic cv, input logic exp_det, input string tag);
        logic e;
        @(negedge clock);
        in_valid          = v;
        in_bit            = b;
        start             = st;
        stop              = sp;
        irq_clr           = clr;
        cfg_bus.cfg_valid = cv;
        exp_q.push_back(exp_det);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(det), 32'(e));
        end
    endtask

    task automatic send(input logic b, input logic exp_det, input string tag);
        step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, exp_det, tag);
    endtask

    task automatic nop(input string tag);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic go(input logic st, input logic sp, input string tag);
        step(1'b0, 1'b0, st, sp, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic load_cfg(input logic [MAXLEN-1:0] pat, input logic [LEN_W-1:0] len,
                            input logic [CNT_W-1:0] thr, input logic ovl,
                            input logic exp_ready, input string tag);
        cfg_bus.cfg_pattern = pat;
        cfg_bus.cfg_len     = len;
        cfg_bus.cfg_thresh  = thr;
        cfg_bus.cfg_overlap = ovl;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tag);
        chk({tag, "_rdy"}, 32'(cfg_bus.cfg_ready), 32'(exp_ready));
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_bit = 1'b0; irq_clr = 1'b0;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_pattern = '0; cfg_bus.cfg_len = '0;
        cfg_bus.cfg_thresh = '0; cfg_bus.cfg_overlap = 1'b0;
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_irq",   32'(irq),   32'd0);
        chk("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        chk("rst_det",   32'(det),   32'd0);
        @(negedge clock);
        reset = 1'b1;

        // start without any configuration is ignored
        go(1'b1, 1'b0, "nocfg_start");
        nop("nocfg_nop");
        chk("nocfg_state", 32'(state), 32'd0);
        chk("nocfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);

        // 1: pattern 101, overlapping
        load_cfg(8'b101, 4'd3, 8'd0, 1'b1, 1'b1, "t1_cfg");
        go(1'b1, 1'b0, "t1_start");
        send(1'b1, 1'b0, "t1_b1");
        send(1'b0, 1'b0, "t1_b2");
        send(1'b1, 1'b1, "t1_b3");
        send(1'b0, 1'b0, "t1_b4");
        send(1'b1, 1'b1, "t1_b5");
        nop("t1_nop");
        chk("t1_count", 32'(count), 32'd2);
        chk("t1_state", 32'(state), 32'd1);

        // 2: pattern 101, non-overlapping
        go(1'b0, 1'b1, "t2_stop");
        nop("t2_nop0");
        chk("t2_idle_state", 32'(state), 32'd0);
        chk("t2_idle_count", 32'(count), 32'd2);
        load_cfg(8'b101, 4'd3, 8'd0, 1'b0, 1'b1, "t2_cfg");
        go(1'b1, 1'b0, "t2_start");
        send(1'b1, 1'b0, "t2_b1");
        send(1'b0, 1'b0, "t2_b2");
        send(1'b1, 1'b1, "t2_b3");
        send(1'b0, 1'b0, "t2_b4");
        send(1'b1, 1'b0, "t2_b5");
        nop("t2_nop1");
        chk("t2_count_a", 32'(count), 32'd1);
        send(1'b0, 1'b0, "t2_b6");
        send(1'b1, 1'b1, "t2_b7");
        nop("t2_nop2");
        chk("t2_count_b", 32'(count), 32'd2);

        // 3: pattern 0011, threshold 2; irq_clr on the set cycle loses to the set
        go(1'b0, 1'b1, "t3_stop");
        load_cfg(8'b0011, 4'd4, 8'd2, 1'b1, 1'b1, "t3_cfg");
        go(1'b1, 1'b0, "t3_start");
        send(1'b0, 1'b0, "t3_b1");
        send(1'b0, 1'b0, "t3_b2");
        send(1'b1, 1'b0, "t3_b3");
        send(1'b1, 1'b1, "t3_b4");
        send(1'b0, 1'b0, "t3_b5");
        send(1'b0, 1'b0, "t3_b6");
        send(1'b1, 1'b0, "t3_b7");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "t3_b8");
        send(1'b0, 1'b0, "t3_done_b1");
        chk("t3_irq_set", 32'(irq),   32'd1);
        chk("t3_state",   32'(state), 32'd2);
        chk("t3_count",   32'(count), 32'd2);
        send(1'b0, 1'b0, "t3_done_b2");
        send(1'b1, 1'b0, "t3_done_b3");
        send(1'b1, 1'b0, "t3_done_b4");
        nop("t3_nop0");
        chk("t3_count_hold", 32'(count), 32'd2);
        chk("t3_ready_done", 32'(cfg_bus.cfg_ready), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t3_clr");
        nop("t3_nop1");
        chk("t3_irq_clr", 32'(irq), 32'd0);
        go(1'b1, 1'b1, "t3_start_stop");
        nop("t3_nop2");
        chk("t3_ss_state", 32'(state), 32'd0);
        chk("t3_ss_count", 32'(count), 32'd2);
        go(1'b1, 1'b0, "t3_restart");
        nop("t3_nop3");
        chk("t3_rs_state", 32'(state), 32'd1);
        chk("t3_rs_count", 32'(count), 32'd0);

        // 4: gap in in_valid does not shift history
        go(1'b0, 1'b1, "t4_stop");
        load_cfg(8'b101, 4'd3, 8'd0, 1'b1, 1'b1, "t4_cfg");
        go(1'b1, 1'b0, "t4_start");
        send(1'b1, 1'b0, "t4_b1");
        send(1'b0, 1'b0, "t4_b2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_gap1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_gap2");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_gap3");
        send(1'b1, 1'b1, "t4_b3");
        nop("t4_nop");
        chk("t4_count", 32'(count), 32'd1);

        // 5: config ignored while running; stop beats start in RUN and IDLE
        load_cfg(8'b111, 4'd3, 8'd1, 1'b0, 1'b0, "t5_cfg_run");
        send(1'b0, 1'b0, "t5_b1");
        send(1'b1, 1'b1, "t5_b2");
        nop("t5_nop0");
        chk("t5_count", 32'(count), 32'd2);
        chk("t5_state_run", 32'(state), 32'd1);
        go(1'b1, 1'b1, "t5_ss_run");
        nop("t5_nop1");
        chk("t5_ss_run_state", 32'(state), 32'd0);
        go(1'b1, 1'b1, "t5_ss_idle");
        nop("t5_nop2");
        chk("t5_ss_idle_state", 32'(state), 32'd0);

        // 6: reset mid-stream drops everything including the configuration
        go(1'b1, 1'b0, "t6_start");
        send(1'b1, 1'b0, "t6_b1");
        send(1'b0, 1'b0, "t6_b2");
        send(1'b1, 1'b1, "t6_b3");
        send(1'b0, 1'b0, "t6_b4");
        chk("t6_count_pre", 32'(count), 32'd1);
        @(negedge clock);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        reset    = 1'b0;
        #1;
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_irq",   32'(irq),   32'd0);
        chk("t6_rst_det",   32'(det),   32'd0);
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        go(1'b1, 1'b0, "t6_start_nocfg");
        nop("t6_nop0");
        chk("t6_nocfg_state", 32'(state), 32'd0);
        load_cfg(8'b101, 4'd0, 8'd1, 1'b1, 1'b1, "t6_cfg");
        go(1'b1, 1'b0, "t6_restart");
        nop("t6_nop1");
        chk("t6_run_state", 32'(state), 32'd1);

        // length 0 clamps to 8 and thresh=1 finishes on the first match
        send(1'b0, 1'b0, "t7_b1");
        send(1'b0, 1'b0, "t7_b2");
        send(1'b0, 1'b0, "t7_b3");
        send(1'b0, 1'b0, "t7_b4");
        send(1'b0, 1'b0, "t7_b5");
        send(1'b1, 1'b0, "t7_b6");
        send(1'b0, 1'b0, "t7_b7");
        send(1'b1, 1'b1, "t7_b8");
        nop("t7_nop");
        chk("t7_state", 32'(state), 32'd2);
        chk("t7_irq",   32'(irq),   32'd1);
        chk("t7_count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_det_ctrl.md
Name: pattern_det_ctrl

Overview:
Programmable serial pattern-detector controller. Replaces the fixed-sequence Mealy detectors with one block that software configures through a valid/ready handshake, then starts and stops. While running it counts matches and raises a sticky interrupt at a programmed threshold. It sits between the config/CPU side and a 1-bit serial input stream.

Parameters:
MAXLEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of the match counter and threshold
LEN_W, $clog2(MAXLEN+1), width of cfg_len

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cfg_valid  in  1  config word valid
cfg_ready  out  1  config accepted this cycle if cfg_valid; high only in IDLE
cfg_pattern  in  MAXLEN  pattern; bit [len-1] is the first received bit, bit [0] the last
cfg_len  in  LEN_W  pattern length; 0 or >MAXLEN is clamped to MAXLEN
cfg_thresh  in  CNT_W  match count that raises irq; 0 means never
cfg_overlap  in  1  1 = overlapping matches allowed
start  in  1  begin or restart detection
stop  in  1  abort to IDLE
in_valid  in  1  serial bit qualifier
in  in  1  serial data bit
det  out  1  Mealy match strobe, combinational
count  out  CNT_W  matches since the last start; saturates at all-ones
irq  out  1  sticky threshold interrupt
irq_clr  in  1  clears irq
state  out  2  IDLE=00, RUN=01, DONE=10

Behaviour:
- Reset (reset=0, async) sets:
  - state=IDLE, count=0, irq=0, cfg_loaded=0.
  - Pattern, length, threshold and overlap registers, hist, and fill all 0.
  - Outputs: cfg_ready=1, det=0.
- Config:
  - cfg_valid & cfg_ready latches cfg_* (with length clamped) and sets cfg_loaded.
  - cfg_ready=0 in RUN and DONE, so cfg_valid is ignored there.
- History:
  - hist is a (MAXLEN-1)-bit shift register; newest bit is in the LSB.
  - fill counts accepted bits and saturates at MAXLEN.
  - Both update only when state==RUN & in_valid & !stop.
- Match:
  - win = {hist, in}; match = (win[len-1:0] == pattern[len-1:0]) & (fill >= len-1).
  - det = (state==RUN) & in_valid & !stop & match. It is valid in the same cycle as the bit, with zero latency.
- On a det cycle:
  - count increments, saturating.
  - If overlap=0, fill resets to 0 at the next edge, so matching bits are not reused. The hist contents are irrelevant after that.
- State machine:
  - IDLE: start & cfg_loaded & !stop -> RUN. On entry, clear count, hist and fill; clear irq. start without cfg_loaded is ignored.
  - RUN: stop -> IDLE. If det and (count+1)==thresh with thresh!=0: set irq and go to DONE at the same edge.
  - DONE: det is forced to 0 and count holds. start & !stop -> RUN (same entry clears as above). stop -> IDLE.
- Priorities:
  - stop beats start.
  - irq set beats a same-cycle irq_clr.
  - irq_clr outside a set cycle clears irq at the next edge.
- Stop behaviour: stop in RUN suppresses that cycle's det and count update. count and irq are retained in IDLE.
- Threshold edge cases:
  - thresh=0: never DONE; count saturates at 2^CNT_W-1 and holds, while det still pulses.
  - thresh=1: DONE after the first match.
- Reset mid-run: immediate return to the reset values. The configuration is lost, so a new config transfer is required before start.
- in_valid=0 in RUN: no shift, no det, no count change.

Test Plan:
1. Config 101 (pattern=...101, len=3, overlap=1, thresh=0), start; send 1,0,1,0,1 -> det high on bits 3 and 5; count=2; state stays 01.
2. Same stream with overlap=0 -> det only on bit 3; count=1. Then send 0,1 -> det on the 7th bit; count=2.
3. Config 0011 (len=4, thresh=2, overlap=1); send 0,0,1,1,0,0,1,1 -> det on bits 4 and 8. irq=1 and state=10 the cycle after bit 8. Further 0011 gives det=0 and count stays 2. irq_clr -> irq=0. Start -> state=01, count=0.
4. Config 101, start, 1,0 with in_valid dropped for 3 cycles, then 1 -> det only on the valid 1. No shifting during the gap.
5. start before any config -> state stays 00, cfg_ready=1. start and stop together in IDLE/DONE -> stop wins; cfg_valid during RUN -> cfg_ready=0 and the config is unchanged.
6. Run with count=1 after one match, then assert reset low mid-stream -> immediately state=00, count=0, irq=0, det=0. start after reset is ignored until a new config is accepted.
